// File: rtl/ex_div_ctrl_if.sv
// ex_div_ctrl_if -- bus between the EX-stage divide controller and the
// iterative divider.
//   master : controller side (drives start and the latched request fields,
//            receives result and ready)
//   slave  : divider side
// Signals:
//   div_start_o     level start, held for the whole operation
//   div_dividend_o  latched rs1
//   div_divisor_o   latched rs2
//   div_op_o        latched funct3
//   div_waddr_o     latched destination register
//   div_result_i    divider result, valid with div_ready_i
//   div_ready_i     one-cycle completion pulse
interface ex_div_ctrl_if;
  logic        div_start_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [2:0]  div_op_o;
  logic [4:0]  div_waddr_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;

  modport master (
    output div_start_o, div_dividend_o, div_divisor_o, div_op_o, div_waddr_o,
    input  div_result_i, div_ready_i
  );

  modport slave (
    input  div_start_o, div_dividend_o, div_divisor_o, div_op_o, div_waddr_o,
    output div_result_i, div_ready_i
  );
endinterface

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl -- EX-stage sequencer for DIV/DIVU/REM/REMU.
// Accepts a divide request, holds the pipeline while an external iterative
// divider works, writes the result back for one cycle, and aborts with an
// error pulse if the divider does not answer within TIMEOUT_CYC cycles.
//
// Parameters:
//   TIMEOUT_CYC  WAIT cycles before abort (legal 40..1023)
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req_i                      divide instruction valid in EX
//   op_i                       funct3 (100 DIV, 101 DIVU, 110 REM, 111 REMU)
//   rs1_data_i, rs2_data_i     dividend, divisor
//   rd_waddr_i                 destination register
//   flush_i                    pipeline flush, kills the in-flight op
//   div_if (master)            divider bus, see ex_div_ctrl_if
//   stall_o                    hold IF/ID/EX while the op is outstanding
//   wb_we_o/wb_waddr_o/wb_wdata_o  one-cycle write-back
//   err_o                      one-cycle timeout pulse
// Optional feature:
//   DIV_RESULT_REUSE_EN  single-entry cache of the last completed divide;
//                        an identical request skips the divider.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no op outstanding, waiting for req_i
// S_WAIT | divider running, start held, timeout counter advancing
// S_WB   | one-cycle write-back of the registered result
module ex_div_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_i,
  input  logic [2:0]    op_i,
  input  logic [31:0]   rs1_data_i,
  input  logic [31:0]   rs2_data_i,
  input  logic [4:0]    rd_waddr_i,
  input  logic          flush_i,
  ex_div_ctrl_if.master div_if,
  output logic          stall_o,
  output logic          wb_we_o,
  output logic [4:0]    wb_waddr_o,
  output logic [31:0]   wb_wdata_o,
  output logic          err_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_WB   = 3'b100
  } state_e;

  // Abort is taken in the last WAIT cycle, so start is high for exactly
  // TIMEOUT_CYC cycles and err_o appears in the first IDLE cycle after.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        stall_c;
  logic        start_c;
  logic        hit;
  logic [31:0] hit_data;

`ifdef DIV_RESULT_REUSE_EN
  logic        c_vld_q;
  logic [2:0]  c_op_q;
  logic [31:0] c_rs1_q;
  logic [31:0] c_rs2_q;
  logic [31:0] c_res_q;

  assign hit      = c_vld_q && (c_op_q == op_i) &&
                    (c_rs1_q == rs1_data_i) && (c_rs2_q == rs2_data_i);
  assign hit_data = c_res_q;

  // Filled on every divider completion that is not flushed; a flush leaves
  // the entry alone, only reset invalidates it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_vld_q <= 1'b0;
      c_op_q  <= '0;
      c_rs1_q <= '0;
      c_rs2_q <= '0;
      c_res_q <= '0;
    end else if (state_q == S_WAIT && div_if.div_ready_i && !flush_i) begin
      c_vld_q <= 1'b1;
      c_op_q  <= op_q;
      c_rs1_q <= rs1_q;
      c_rs2_q <= rs2_q;
      c_res_q <= div_if.div_result_i;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    stall_c = 1'b0;
    start_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_i && !flush_i) begin
          op_d  = op_i;
          rs1_d = rs1_data_i;
          rs2_d = rs2_data_i;
          rd_d  = rd_waddr_i;
          if (hit) begin
            wdata_d = hit_data;
            state_d = S_WB;
          end else begin
            stall_c = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        stall_c = 1'b1;
        // Start drops in the ready cycle so the divider never sees a
        // second start right after its completion pulse.
        start_c = !div_if.div_ready_i && !flush_i;
        cnt_d   = cnt_q + 10'd1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (div_if.div_ready_i) begin
          wdata_d = div_if.div_result_i;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WB: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // stall_c can be high in IDLE from req_i alone; gating with rstn keeps
  // every output at 0 while reset is asserted.
  assign stall_o = stall_c & rstn;

  assign div_if.div_start_o    = start_c;
  assign div_if.div_dividend_o = rs1_q;
  assign div_if.div_divisor_o  = rs2_q;
  assign div_if.div_op_o       = op_q;
  assign div_if.div_waddr_o    = rd_q;

  // rd = x0 still runs the full sequence, only the write enable is masked.
  assign wb_we_o    = (state_q == S_WB) && (rd_q != 5'd0);
  assign wb_waddr_o = rd_q;
  assign wb_wdata_o = wdata_q;
  assign err_o      = err_q;

endmodule
